wb_fb_slave: RTL and testbench
==============================

Name: wb_fb_slave

Overview:
- 32-bit Wishbone B3 slave that owns the framebuffer memory port and answers the display redraw master's pipelined read bursts.
- Also accepts single-beat CPU writes and reads.
- Sits between the video subsystem's redraw master port and a synchronous SRAM/block-RAM style framebuffer port with fixed 1-cycle read latency.

Parameters:
- ADDRESS, 21, word-address width of wb_adr_i and mem_adr_o (ASB = ADDRESS-1).
- FB_WORDS, 2**ADDRESS, number of implemented words; addresses >= FB_WORDS get an error response.

Ports:
- wb_clk_i  in  1  bus/memory clock.
- wb_rst_i  in  1  synchronous active-high reset.
- wb_cyc_i  in  1  cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write.
- wb_cti_i  in  3  000 classic, 010 incrementing burst, 111 end-of-burst.
- wb_bte_i  in  2  00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wb_adr_i  in  ADDRESS  word address.
- wb_sel_i  in  4  byte selects (writes).
- wb_dat_i  in  32  write data.
- wb_ack_o  out  1  normal termination.
- wb_rty_o  out  1  tied 0.
- wb_err_o  out  1  error termination.
- wb_sel_o  out  4  always 4'hF.
- wb_dat_o  out  32  read data.
- mem_re_o  out  1  memory read enable; data appears on mem_dat_i one cycle later.
- mem_we_o  out  1  memory write enable, one cycle per write beat.
- mem_bes_o  out  4  byte enables.
- mem_adr_o  out  ADDRESS  memory word address.
- mem_dat_o  out  32  write data.
- mem_dat_i  in  32  read data.

Behaviour:
- Reset: all outputs are 0 except wb_sel_o = 4'hF; state is IDLE; the skid register is invalid.
- A synchronous reset mid-burst drops ack/err the next edge, with no further memory access.
- States: IDLE, RD1, BURST, WR, ERR.
- IDLE, on cyc&stb:
  - Out-of-range address -> ERR.
  - Write -> WR.
  - Read with cti=010 -> BURST.
  - Any other read -> RD1.
  - The memory access is issued in the same cycle as the request: mem_re_o/mem_we_o asserted combinationally from the IDLE decode, with mem_adr_o = wb_adr_i.
- RD1 (classic read, one wait state):
  - wb_ack_o = 1 and wb_dat_o = mem_dat_i for exactly one cycle.
  - Then return to IDLE; a new request can be accepted that cycle.
- BURST:
  - First ack comes 1 cycle after the request. After that, one ack per cycle while stb stays high (zero wait states).
  - Next address = current+1, wrapped per wb_bte_i within aligned 4/8/16-word blocks; linear wraps modulo 2^ADDRESS.
  - The next read is issued speculatively each cycle.
  - Master wait state (stb low while cyc high): wb_ack_o = 0. The in-flight word is captured in a 1-entry skid register and presented, with ack, when stb returns. No new read is issued while the skid is full.
  - Beat with cti=111: acked normally, no further speculative read, then IDLE.
  - Burst address crossing FB_WORDS: that beat gets wb_err_o instead of ack, then IDLE.
- WR:
  - mem_we_o pulses exactly once, in the request cycle, with mem_bes_o = wb_sel_i and mem_dat_o = wb_dat_i.
  - wb_ack_o = 1 next cycle, then IDLE.
  - Write bursts (cti=010) are handled as consecutive classic writes, each with one wait state.
- ERR: wb_err_o = 1 for one cycle; no memory access occurs; then IDLE.
- cyc dropped in any state: next edge goes to IDLE, skid cleared, no ack/err.
- ack and err are never asserted together, and never without cyc&stb in the same cycle.

Optional Feature:
- Macro: WB_FB_WRAP_EN.
- Defined: wb_bte_i wrap modes are honoured as above.
- Undefined: wb_bte_i is ignored, all bursts increment linearly, and the wrap logic is not built.

Test Plan:
- Classic read at 0x00010, memory word 0xDEADBEEF -> mem_re_o with adr 0x00010 in cycle 0; ack with dat 0xDEADBEEF in cycle 1 only.
- Linear burst of 8 from 0x00100, stb held, cti=111 on beat 8 -> acks on 8 consecutive cycles starting cycle 1, data from 0x100..0x107; no mem_re_o after the read of 0x107.
- Burst from 0x00200, stb dropped for 3 cycles after beat 2 -> no ack during the gap; beat 3 returns word 0x202 from skid; total 3 reads issued before the gap, none during it.
- WB_FB_WRAP_EN defined, wrap4 burst from 0x00006 for 4 beats -> addresses 6,7,4,5. Undefined -> 6,7,8,9.
- Write 0x12345678 to 0x00020 with sel=4'b0011 -> single mem_we_o pulse with bes 0011; ack one cycle later; read-back gives low halfword 0x5678.
- Read at FB_WORDS -> err for one cycle, no ack, no mem_re_o. Reset asserted mid-burst -> ack=0 next edge, state IDLE.

Source files
------------

// File: rtl/wb_fb_slave.sv
`default_nettype none
// ============================================================================
// Module   : wb_fb_slave
// Brief    : Wishbone B3 framebuffer slave; pipelined read bursts with a
//            1-entry skid buffer, single-beat writes, 1-cycle-latency memory.
//            Optional macro WB_FB_WRAP_EN enables wb_bte_i wrap bursts.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fb_slave #(
    parameter int ADDRESS  = 21,
    parameter int FB_WORDS = 2**ADDRESS
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [2:0]          wb_cti_i,
    input  logic [1:0]          wb_bte_i,
    input  logic [ADDRESS-1:0]  wb_adr_i,
    input  logic [3:0]          wb_sel_i,
    input  logic [31:0]         wb_dat_i,
    output logic                wb_ack_o,
    output logic                wb_rty_o,
    output logic                wb_err_o,
    output logic [3:0]          wb_sel_o,
    output logic [31:0]         wb_dat_o,
    output logic                mem_re_o,
    output logic                mem_we_o,
    output logic [3:0]          mem_bes_o,
    output logic [ADDRESS-1:0]  mem_adr_o,
    output logic [31:0]         mem_dat_o,
    input  logic [31:0]         mem_dat_i
);

    localparam logic [ADDRESS:0]   c_fb_limit = (ADDRESS+1)'(FB_WORDS);
    localparam logic [ADDRESS-1:0] c_one      = ADDRESS'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD1   = 3'd1,
        S_BURST = 3'd2,
        S_WR    = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDRESS-1:0]  r_adr;       // address of the word pending or held in skid
    logic                r_pend;      // read issued last cycle, data on mem_dat_i now
    logic                r_skid_vld;
    logic [31:0]         r_skid;
    logic                r_oor;       // next burst beat lies beyond FB_WORDS

    logic                w_req;
    logic                w_idle_req;
    logic                w_oor_req;
    logic                w_last;
    logic [ADDRESS-1:0]  w_next_adr;
    logic                w_next_oor;
    logic                w_beat;
    logic                w_spec_rd;

`ifdef WB_FB_WRAP_EN
    logic [ADDRESS-1:0]  w_wrap_mask;

    always_comb begin
        w_wrap_mask = '1;
        case (wb_bte_i)
            2'b01:   w_wrap_mask = ADDRESS'(3);
            2'b10:   w_wrap_mask = ADDRESS'(7);
            2'b11:   w_wrap_mask = ADDRESS'(15);
            default: w_wrap_mask = '1;
        endcase
    end

    assign w_next_adr = (r_adr & ~w_wrap_mask) | ((r_adr + c_one) & w_wrap_mask);
`else
    logic w_unused;

    assign w_unused   = &{1'b0, wb_bte_i};
    assign w_next_adr = r_adr + c_one;
`endif

    assign w_req      = wb_cyc_i & wb_stb_i;
    assign w_idle_req = (r_state == S_IDLE) & w_req;
    assign w_oor_req  = {1'b0, wb_adr_i} >= c_fb_limit;
    assign w_next_oor = {1'b0, w_next_adr} >= c_fb_limit;
    assign w_last     = (wb_cti_i == 3'b111);

    // A beat completes when its word is either in flight or parked in the skid.
    assign w_beat    = (r_state == S_BURST) & w_req & ~r_oor & (r_pend | r_skid_vld);
    assign w_spec_rd = w_beat & ~w_last & ~w_next_oor;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= S_IDLE;
            r_adr      <= '0;
            r_pend     <= 1'b0;
            r_skid_vld <= 1'b0;
            r_skid     <= '0;
            r_oor      <= 1'b0;
        end else begin
            r_pend <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_skid_vld <= 1'b0;
                    r_oor      <= 1'b0;
                    if (w_req) begin
                        r_adr <= wb_adr_i;
                        if (w_oor_req) begin
                            r_state <= S_ERR;
                        end else if (wb_we_i) begin
                            r_state <= S_WR;
                        end else if (wb_cti_i == 3'b010) begin
                            r_state <= S_BURST;
                            r_pend  <= 1'b1;
                        end else begin
                            r_state <= S_RD1;
                        end
                    end
                end
                S_BURST: begin
                    if (!wb_cyc_i) begin
                        r_state    <= S_IDLE;
                        r_skid_vld <= 1'b0;
                        r_oor      <= 1'b0;
                    end else if (wb_stb_i && r_oor) begin
                        r_state <= S_IDLE;
                    end else if (w_beat) begin
                        r_skid_vld <= 1'b0;
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end else if (w_next_oor) begin
                            r_oor <= 1'b1;
                        end else begin
                            r_adr  <= w_next_adr;
                            r_pend <= 1'b1;
                        end
                    end else if (!wb_stb_i && r_pend) begin
                        r_skid     <= mem_dat_i;
                        r_skid_vld <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory access is launched straight from the IDLE decode to hide latency.
    assign mem_re_o  = ~wb_rst_i & ((w_idle_req & ~wb_we_i & ~w_oor_req) | w_spec_rd);
    assign mem_we_o  = ~wb_rst_i & w_idle_req & wb_we_i & ~w_oor_req;
    assign mem_adr_o = wb_rst_i ? '0 : ((r_state == S_IDLE) ? wb_adr_i : w_next_adr);
    assign mem_bes_o = mem_we_o ? wb_sel_i : (mem_re_o ? 4'hF : 4'h0);
    assign mem_dat_o = mem_we_o ? wb_dat_i : '0;

    assign wb_ack_o = ~wb_rst_i & w_req &
                      ((r_state == S_RD1) | (r_state == S_WR) | w_beat);
    assign wb_err_o = ~wb_rst_i & w_req &
                      ((r_state == S_ERR) | ((r_state == S_BURST) & r_oor));
    assign wb_dat_o = ~wb_ack_o ? '0 :
                      (((r_state == S_BURST) && r_skid_vld) ? r_skid : mem_dat_i);
    assign wb_rty_o = 1'b0;
    assign wb_sel_o = 4'hF;

endmodule
`default_nettype wire

// File: tb/tb_wb_fb_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_fb_slave
// Brief    : Directed self-checking bench for wb_fb_slave with a memory model
//            and a queue of expected read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_fb_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [20:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic        wb_ack, wb_rty, wb_err;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat;
    logic        mem_re, mem_we;
    logic [3:0]  mem_bes;
    logic [20:0] mem_adr;
    logic [31:0] mem_wdat, mem_rd;

    int          checks = 0;
    int          errors = 0;
    int          rd_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    wb_fb_slave #(.ADDRESS(21), .FB_WORDS(4096)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_we_i(we), .wb_cti_i(cti), .wb_bte_i(bte), .wb_adr_i(adr),
        .wb_sel_i(sel), .wb_dat_i(wdat), .wb_ack_o(wb_ack), .wb_rty_o(wb_rty),
        .wb_err_o(wb_err), .wb_sel_o(wb_sel), .wb_dat_o(wb_dat),
        .mem_re_o(mem_re), .mem_we_o(mem_we), .mem_bes_o(mem_bes),
        .mem_adr_o(mem_adr), .mem_dat_o(mem_wdat), .mem_dat_i(mem_rd)
    );

    function automatic logic [31:0] pat(input logic [20:0] a);
        return (a == 21'h10) ? 32'hDEADBEEF : (32'h5A000000 | 32'(a));
    endfunction

    // Synchronous framebuffer with one cycle of read latency.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(21'(i));
        end else begin
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_bes[b]) mem[mem_adr[11:0]][8*b +: 8] <= mem_wdat[8*b +: 8];
            if (mem_re) mem_rd <= mem[mem_adr[11:0]];
        end
        if (mem_re) rd_cnt <= rd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 32'(obs), 32'(exp));
    endtask

    task automatic chk_beat(input string tag);
        logic [31:0] e;
        e = 32'hxxxxxxxx;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk1({tag, "_ack"}, wb_ack, 1'b1);
        chk1({tag, "_err"}, wb_err, 1'b0);
        chk({tag, "_dat"}, wb_dat, e);
    endtask

    // Applies bus signals just after a rising edge and returns at the falling edge.
    task automatic drive(input logic c, input logic s, input logic w, input logic [2:0] t,
                         input logic [1:0] b, input logic [20:0] a,
                         input logic [3:0] se = 4'hF, input logic [31:0] d = 32'h0);
        @(posedge clk);
        #1;
        cyc = c; stb = s; we = w; cti = t; bte = b; adr = a; sel = se; wdat = d;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 21'h0, 4'h0, 32'h0);
    endtask

    initial begin
        int          base;
        logic [20:0] a;
        logic [31:0] w;
        logic [20:0] wa [4];
`ifdef WB_FB_WRAP_EN
        wa = '{21'h6, 21'h7, 21'h4, 21'h5};
`else
        wa = '{21'h6, 21'h7, 21'h8, 21'h9};
`endif
        rst = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
        adr = '0; sel = 4'h0; wdat = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_ack", wb_ack, 1'b0);
        chk1("rst_err", wb_err, 1'b0);
        chk1("rst_rty", wb_rty, 1'b0);
        chk("rst_sel", 32'(wb_sel), 32'hF);
        chk1("rst_re", mem_re, 1'b0);
        chk1("rst_we", mem_we, 1'b0);
        chk("rst_dat", wb_dat, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Classic read
        drive(1'b1, 1'b1, 1'b0, 3'b000, 2'b00, 21'h10);
        exp_q.push_back(32'hDEADBEEF);
        chk1("rd_re0", mem_re, 1'b1);
        chk("rd_adr0", 32'(mem_adr), 32'h10);
        chk1("rd_ack0", wb_ack, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 3'b000, 2'b00, 21'h10);
        chk_beat("rd_beat");
        chk1("rd_re1", mem_re, 1'b0);
        idle();
        chk1("rd_ack2", wb_ack, 1'b0);

        // Linear burst of 8
        base = rd_cnt;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 2'b00, 21'h100);
        chk1("bl_re0", mem_re, 1'b1);
        chk("bl_adr0", 32'(mem_adr), 32'h100);
        for (int k = 1; k <= 8; k++) begin
            a = 21'h100 + 21'(k - 1);
            drive(1'b1, 1'b1, 1'b0, (k == 8) ? 3'b111 : 3'b010, 2'b00, a);
            exp_q.push_back(pat(a));
            chk_beat("bl_beat");
            if (k < 8) chk("bl_spec_adr", 32'(mem_adr), 32'(a + 21'h1));
            chk1("bl_spec_re", mem_re, k < 8);
        end
        idle();
        chk1("bl_done_ack", wb_ack, 1'b0);
        chk("bl_reads", 32'(rd_cnt - base), 32'd8);

        // Burst with a three-cycle master wait state
        base = rd_cnt;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 2'b00, 21'h200);
        for (int k = 1; k <= 2; k++) begin
            a = 21'h200 + 21'(k - 1);
            drive(1'b1, 1'b1, 1'b0, 3'b010, 2'b00, a);
            exp_q.push_back(pat(a));
            chk_beat("sk_beat");
        end
        repeat (3) begin
            drive(1'b1, 1'b0, 1'b0, 3'b010, 2'b00, 21'h202);
            chk1("sk_gap_ack", wb_ack, 1'b0);
            chk1("sk_gap_re", mem_re, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b0, 3'b010, 2'b00, 21'h202);
        exp_q.push_back(pat(21'h202));
        chk("sk_reads", 32'(rd_cnt - base), 32'd3);
        chk_beat("sk_skid_beat");
        chk1("sk_resume_re", mem_re, 1'b1);
        chk("sk_resume_adr", 32'(mem_adr), 32'h203);
        drive(1'b1, 1'b1, 1'b0, 3'b111, 2'b00, 21'h203);
        exp_q.push_back(pat(21'h203));
        chk_beat("sk_last");
        chk1("sk_last_re", mem_re, 1'b0);
        idle();

        // Wrap4 burst (linear when wrap support is not built)
        drive(1'b1, 1'b1, 1'b0, 3'b010, 2'b01, 21'h6);
        chk("wr4_adr0", 32'(mem_adr), 32'(wa[0]));
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b1, 1'b0, (k == 4) ? 3'b111 : 3'b010, 2'b01, wa[k-1]);
            exp_q.push_back(pat(wa[k-1]));
            chk_beat("wr4_beat");
            if (k < 4) chk("wr4_adr", 32'(mem_adr), 32'(wa[k]));
        end
        idle();

        // Partial write then read-back
        drive(1'b1, 1'b1, 1'b1, 3'b000, 2'b00, 21'h20, 4'b0011, 32'h12345678);
        chk1("wr_we0", mem_we, 1'b1);
        chk1("wr_re0", mem_re, 1'b0);
        chk("wr_bes", 32'(mem_bes), 32'h3);
        chk("wr_dat", mem_wdat, 32'h12345678);
        chk("wr_adr", 32'(mem_adr), 32'h20);
        chk1("wr_ack0", wb_ack, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 3'b000, 2'b00, 21'h20, 4'b0011, 32'h12345678);
        chk1("wr_ack1", wb_ack, 1'b1);
        chk1("wr_we1", mem_we, 1'b0);
        idle();
        chk1("wr_ack2", wb_ack, 1'b0);
        w = pat(21'h20);
        w[15:0] = 16'h5678;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 2'b00, 21'h20);
        exp_q.push_back(w);
        drive(1'b1, 1'b1, 1'b0, 3'b000, 2'b00, 21'h20);
        chk_beat("wr_readback");
        idle();

        // Out-of-range classic read
        drive(1'b1, 1'b1, 1'b0, 3'b000, 2'b00, 21'h1000);
        chk1("oor_re", mem_re, 1'b0);
        chk1("oor_err0", wb_err, 1'b0);
        chk1("oor_ack0", wb_ack, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 3'b000, 2'b00, 21'h1000);
        chk1("oor_err1", wb_err, 1'b1);
        chk1("oor_ack1", wb_ack, 1'b0);
        idle();
        chk1("oor_err2", wb_err, 1'b0);

        // Burst running off the end of the framebuffer
        drive(1'b1, 1'b1, 1'b0, 3'b010, 2'b00, 21'hFFE);
        for (int k = 1; k <= 2; k++) begin
            a = 21'hFFE + 21'(k - 1);
            drive(1'b1, 1'b1, 1'b0, 3'b010, 2'b00, a);
            exp_q.push_back(pat(a));
            chk_beat("cross_beat");
        end
        chk1("cross_no_re", mem_re, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 2'b00, 21'h1000);
        chk1("cross_err", wb_err, 1'b1);
        chk1("cross_ack", wb_ack, 1'b0);
        idle();
        chk1("cross_err_end", wb_err, 1'b0);

        // Cycle dropped with a full skid: the stale word must not leak out
        drive(1'b1, 1'b1, 1'b0, 3'b010, 2'b00, 21'h400);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 2'b00, 21'h400);
        exp_q.push_back(pat(21'h400));
        chk_beat("drop_beat");
        drive(1'b1, 1'b0, 1'b0, 3'b010, 2'b00, 21'h401);
        chk1("drop_gap_ack", wb_ack, 1'b0);
        idle();
        chk1("drop_ack", wb_ack, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 2'b00, 21'h500);
        drive(1'b1, 1'b1, 1'b0, 3'b111, 2'b00, 21'h500);
        exp_q.push_back(pat(21'h500));
        chk_beat("drop_new_beat");
        idle();

        // Reset in the middle of a burst
        drive(1'b1, 1'b1, 1'b0, 3'b010, 2'b00, 21'h300);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 2'b00, 21'h300);
        exp_q.push_back(pat(21'h300));
        chk_beat("mrst_beat");
        @(posedge clk);
        #1 rst = 1'b1;
        adr = 21'h301;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 2'b00, 21'h302);
        chk1("mrst_ack", wb_ack, 1'b0);
        chk1("mrst_err", wb_err, 1'b0);
        chk1("mrst_re", mem_re, 1'b0);
        idle();
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 2'b00, 21'h10);
        exp_q.push_back(32'hDEADBEEF);
        chk1("mrst_idle_re", mem_re, 1'b1);
        chk1("mrst_idle_ack", wb_ack, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 3'b000, 2'b00, 21'h10);
        chk_beat("mrst_rd");
        idle();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
